threedo_pad_reader: RTL and testbench
=====================================

// Module: threedo_pad_reader
// PURPOSE
//  Console-side master for the 3DO controller serial port; the opposite end of our threedeeohpad emulator.
//  Generates ps (latch) and pad_clk and shifts in dat MSB-first.
//  Presents each completed frame as a parallel word with a one-cycle valid strobe.
//  Used to bench-drive pad emulators and to read real 3DO pads on the multi-out board.
// PARAMETERS
//  CLK_DIV   260  system_clock cycles per pad_clk half-period (13 us @ 20 MHz)
//  NUM_BITS  32   data bits shifted per frame
//  POLL_GAP  2000 idle system_clock cycles between frames (THREEDO_AUTOPOLL_EN only)
// PORTS
//  system_clock  in   1         single clock, all logic on rising edge
//  reset         in   1         asynchronous, active-high
//  start         in   1         request one frame; honoured only when busy=0
//  dat           in   1         serial data from pad; asynchronous to system_clock
//  ps            out  1         latch/parallel-select to pad; high when idle
//  pad_clk       out  1         serial clock to pad; low when idle
//  data          out  NUM_BITS  last complete frame; first bit received is data[NUM_BITS-1]
//  valid         out  1         one-cycle pulse when data updates
//  busy          out  1         high from frame accept until the cycle valid pulses
// BEHAVIOUR
//  Reset values: ps=1, pad_clk=0, data=0, valid=0, busy=0, FSM=IDLE, all counters 0.
//  dat passes a 2-flop synchroniser before use; ps, pad_clk, valid, busy are registered outputs.
//  Half-period counter runs 0..CLK_DIV-1; a phase ends when it reaches CLK_DIV-1.
//  FSM
//   IDLE: ps=1, pad_clk=0. start=1 -> LATCH_LO, busy=1 next cycle.
//   LATCH_LO: ps=1, pad_clk=0 for CLK_DIV cycles -> LATCH_HI.
//   LATCH_HI: ps=1, pad_clk=1 for CLK_DIV cycles -> SHIFT_LO; ps drops and pad_clk falls in the same cycle.
//   SHIFT_LO: ps=0, pad_clk=0 for CLK_DIV cycles.
//    On the last cycle of the phase, shift synchronised dat into the shift register (shift left, LSB in) -> SHIFT_HI.
//   SHIFT_HI: ps=0, pad_clk=1 for CLK_DIV cycles, then increment bit counter.
//    If bit counter = NUM_BITS -> DONE; otherwise -> SHIFT_LO.
//   DONE: one cycle. data<=shift register, valid=1, busy=0, ps=1, pad_clk=0 -> IDLE (or GAP, see below).
//  Frame timing: 33 pad_clk pulses (1 latch + NUM_BITS data), ps low for exactly the NUM_BITS data pulses.
//  Frame length: start accepted at cycle 0; valid at cycle 2*CLK_DIV*(NUM_BITS+1)+1 (17161 at defaults).
//  data is atomic: it changes only in DONE and holds between frames.
//  Partial frames never reach data.
//  start while busy=1 is ignored, not queued. start in the DONE cycle is also ignored.
//  Back-to-back frames: start held high restarts from IDLE, so the minimum gap is 1 idle cycle with ps=1.
//  Reset mid-frame aborts at once: outputs return to reset values, no valid pulse, the shift register is cleared.
//  Absent pad (dat pulled high) yields data = all ones; no error detection in this block.
//  Counter widths: $clog2(CLK_DIV) and $clog2(NUM_BITS+1); no wrap-around inside a frame.
// CONFIGURATION
//  THREEDO_AUTOPOLL_EN defined:
//   DONE -> GAP. GAP holds ps=1, pad_clk=0 for POLL_GAP cycles, then enters LATCH_LO automatically.
//   After reset, the first frame starts from IDLE without needing start.
//   start is ignored; busy stays 0 only in GAP and IDLE.
//  THREEDO_AUTOPOLL_EN undefined:
//   No GAP state, POLL_GAP unused, frames start only on start.
// TESTING
//  1 Assert reset mid-run -> ps=1, pad_clk=0, data=0, valid=0, busy=0 immediately (asynchronous).
//  2 Pad model shifting 32'hC0060000 MSB-first, 1-cycle start -> valid at cycle 17161, data=32'hC0060000, busy low.
//  3 Count edges over one frame -> exactly 33 pad_clk rising edges; ps low during 32 of them; each half-period 260 cycles.
//  4 Pulse start at cycle 5000 of an active frame -> ignored; a single valid; next start gives a second correct frame.
//  5 Assert reset after the 10th data bit, release, then start with model 32'h0000FFFF -> no stale valid; data=32'h0000FFFF.
//  6 Run with THREEDO_AUTOPOLL_EN and POLL_GAP=2000, start tied low -> valid pulses repeat every 19161 cycles.

Source files
------------

// File: rtl/threedo_pad_reader.sv
// 3DO pad serial master: drives ps/pad_clk, shifts dat in MSB-first, presents each frame with a one-cycle valid.
// Latency: valid 2*CLK_DIV*(NUM_BITS+1)+1 cycles after start is accepted; THREEDO_AUTOPOLL_EN makes polling free-running.
// No backpressure: start is dropped while busy or in DONE; data holds until the next complete frame.
module threedo_pad_reader #(
    parameter int CLK_DIV  = 260,
    parameter int NUM_BITS = 32,
    parameter int POLL_GAP = 2000
) (
    input  logic                system_clock,
    input  logic                reset,
    input  logic                start,
    input  logic                dat,
    output logic                ps,
    output logic                pad_clk,
    output logic [NUM_BITS-1:0] data,
    output logic                valid,
    output logic                busy
);

    localparam int DW = $clog2(CLK_DIV);
    localparam int BW = $clog2(NUM_BITS + 1);

    // Reject parameter values the counters and shift register cannot represent.
    if (CLK_DIV < 2 || NUM_BITS < 2 || POLL_GAP < 2) begin : g_param_check
        $error("threedo_pad_reader: CLK_DIV, NUM_BITS and POLL_GAP must all be >= 2");
    end

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LATCH_LO = 3'd1,
        LATCH_HI = 3'd2,
        SHIFT_LO = 3'd3,
        SHIFT_HI = 3'd4,
        DONE     = 3'd5,
        GAP      = 3'd6
    } state_t;

    state_t                state, state_next;
    logic [DW-1:0]         div_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [NUM_BITS-1:0]   shift_reg;
    logic                  dat_meta, dat_sync;
    logic                  phase_end;
    logic                  timed_phase;
    logic                  shift_en;
    logic                  last_bit;

    assign phase_end   = (div_cnt == DW'(CLK_DIV - 1));
    assign timed_phase = (state == LATCH_LO) || (state == LATCH_HI) ||
                         (state == SHIFT_LO) || (state == SHIFT_HI);
    assign last_bit    = (bit_cnt == BW'(NUM_BITS - 1));

`ifdef THREEDO_AUTOPOLL_EN
    localparam int GW = $clog2(POLL_GAP);
    logic [GW-1:0] gap_cnt;
    logic          gap_end;

    assign gap_end = (gap_cnt == GW'(POLL_GAP - 1));

    always_ff @(posedge system_clock or posedge reset) begin
        if (reset) begin
            gap_cnt <= '0;
        end else if (state == GAP && !gap_end) begin
            gap_cnt <= gap_cnt + 1'b1;
        end else begin
            gap_cnt <= '0;
        end
    end
`endif

    always_comb begin
        state_next = state;
        shift_en   = 1'b0;
        case (state)
            IDLE: begin
`ifdef THREEDO_AUTOPOLL_EN
                state_next = LATCH_LO;
`else
                if (start) state_next = LATCH_LO;
`endif
            end
            LATCH_LO: if (phase_end) state_next = LATCH_HI;
            LATCH_HI: if (phase_end) state_next = SHIFT_LO;
            SHIFT_LO: begin
                if (phase_end) begin
                    shift_en   = 1'b1;
                    state_next = SHIFT_HI;
                end
            end
            SHIFT_HI: if (phase_end) state_next = last_bit ? DONE : SHIFT_LO;
`ifdef THREEDO_AUTOPOLL_EN
            DONE:     state_next = GAP;
            GAP:      if (gap_end) state_next = LATCH_LO;
`else
            DONE:     state_next = IDLE;
`endif
            default:  state_next = IDLE;
        endcase
    end

    // Pad-facing outputs are decoded from the current state and registered, so they trail the FSM by one cycle.
    always_ff @(posedge system_clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            dat_meta  <= 1'b0;
            dat_sync  <= 1'b0;
            data      <= '0;
            ps        <= 1'b1;
            pad_clk   <= 1'b0;
            valid     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state    <= state_next;
            dat_meta <= dat;
            dat_sync <= dat_meta;

            if (state_next != state || !timed_phase) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            if (state != LATCH_LO && state_next == LATCH_LO) begin
                bit_cnt <= '0;
            end else if (state == SHIFT_HI && phase_end) begin
                bit_cnt <= bit_cnt + 1'b1;
            end

            if (shift_en) begin
                shift_reg <= {shift_reg[NUM_BITS-2:0], dat_sync};
            end

            if (state == DONE) begin
                data <= shift_reg;
            end

            ps      <= !((state == SHIFT_LO) || (state == SHIFT_HI));
            pad_clk <= (state == LATCH_HI) || (state == SHIFT_HI);
            valid   <= (state == DONE);
            busy    <= timed_phase;
        end
    end

endmodule

// File: tb/tb_threedo_pad_reader.sv
// Bench for threedo_pad_reader: behavioural pad model, random frame words, frame timing and abort checks.
module tb_threedo_pad_reader;

    localparam int CD        = 5;
    localparam int NB        = 32;
    localparam int FRAME_LAT = 2 * CD * (NB + 1) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          dat;
    logic          ps;
    logic          pad_clk;
    logic [NB-1:0] data;
    logic          valid;
    logic          busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [NB-1:0] pad_word = '0;
    int            k = 0;

    int   valid_cnt  = 0;
    int   rises      = 0;
    int   rises_dat  = 0;
    int   bad_run    = 0;
    int   ps_low_cyc = 0;
    int   run        = 0;
    logic pclk_q     = 1'b0;

    threedo_pad_reader #(.CLK_DIV(CD), .NUM_BITS(NB), .POLL_GAP(2000)) dut (
        .system_clock(clk),
        .reset       (rst),
        .start       (start),
        .dat         (dat),
        .ps          (ps),
        .pad_clk     (pad_clk),
        .data        (data),
        .valid       (valid),
        .busy        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pad: ps high reloads the word; each pad_clk rise with ps low advances to the next bit; past the end reads high.
    always @(posedge pad_clk or posedge ps) begin
        if (ps) k <= 0;
        else    k <= k + 1;
    end
    assign dat = (k < NB) ? pad_word[NB-1-k] : 1'b1;

    always @(negedge clk) begin
        if (valid === 1'b1) valid_cnt <= valid_cnt + 1;
        if (ps === 1'b0) ps_low_cyc <= ps_low_cyc + 1;
        if (pad_clk !== pclk_q) begin
            if (pad_clk === 1'b1) begin
                rises <= rises + 1;
                if (ps === 1'b0) begin
                    rises_dat <= rises_dat + 1;
                    if (run != CD) bad_run <= bad_run + 1;
                end
            end else if (run != CD) begin
                bad_run <= bad_run + 1;
            end
            run <= 1;
        end else begin
            run <= run + 1;
        end
        pclk_q <= pad_clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input int bound, output int at);
        int n;
        n = 0;
        @(negedge clk);
        while (valid !== 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (valid !== 1'b1) begin
            chk("valid_timeout", {63'd0, valid}, 64'd1);
            at = -1;
        end else begin
            at = cyc;
        end
    endtask

    task automatic run_frame(input logic [NB-1:0] word, input int poke, input string tag);
        int acc, at, v0, r0, rd0, b0, p0;
        pad_word = word;
        @(negedge clk);
        v0 = valid_cnt; r0 = rises; rd0 = rises_dat; b0 = bad_run; p0 = ps_low_cyc;
        start = 1'b1;
        acc   = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk({tag, "_busy_on"}, {63'd0, busy}, 64'd1);
        if (poke > 0) begin
            repeat (poke) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_valid(2 * FRAME_LAT, at);
        chk({tag, "_latency"}, 64'(at - acc), 64'(FRAME_LAT));
        chk({tag, "_data"}, 64'(data), 64'(word));
        chk({tag, "_busy_off"}, {63'd0, busy}, 64'd0);
        @(negedge clk);
        chk({tag, "_valid_pulse"}, {63'd0, valid}, 64'd0);
        repeat (2) @(negedge clk);
        chk({tag, "_valid_count"}, 64'(valid_cnt - v0), 64'd1);
        chk({tag, "_clk_rises"}, 64'(rises - r0), 64'(NB + 1));
        chk({tag, "_data_rises"}, 64'(rises_dat - rd0), 64'(NB));
        chk({tag, "_half_periods"}, 64'(bad_run - b0), 64'd0);
        chk({tag, "_ps_low_cycles"}, 64'(ps_low_cyc - p0), 64'(2 * CD * NB));
    endtask

    initial begin
        int a1, a2, v0, rd0, n;
        logic [NB-1:0] w;

        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ps", {63'd0, ps}, 64'd1);
        chk("rst_pad_clk", {63'd0, pad_clk}, 64'd0);
        chk("rst_data", 64'(data), 64'd0);
        chk("rst_valid", {63'd0, valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        run_frame(32'hC0060000, 0, "pattern");

        // A start pulse in mid-frame must neither restart nor queue a frame.
        run_frame($urandom, 150, "ignored_start");
        run_frame($urandom, 0, "after_ignored");

        run_frame(32'hFFFFFFFF, 0, "absent_pad");
        run_frame(32'h00000000, 0, "zeros");
        for (int i = 0; i < 3; i++) run_frame($urandom, 0, "random");

        // Asynchronous reset after the 10th data bit.
        pad_word = $urandom;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rd0 = rises_dat;
        n   = 0;
        while (rises_dat - rd0 < 10 && n < 2 * FRAME_LAT) begin
            @(negedge clk);
            n++;
        end
        chk("abort_point", 64'(rises_dat - rd0), 64'd10);
        #2 rst = 1'b1;
        #1;
        chk("abort_ps", {63'd0, ps}, 64'd1);
        chk("abort_pad_clk", {63'd0, pad_clk}, 64'd0);
        chk("abort_data", 64'(data), 64'd0);
        chk("abort_valid", {63'd0, valid}, 64'd0);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        v0 = valid_cnt;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2 * FRAME_LAT) @(negedge clk);
        chk("abort_no_valid", 64'(valid_cnt - v0), 64'd0);
        chk("abort_data_held", 64'(data), 64'd0);
        run_frame(32'h0000FFFF, 0, "after_abort");

        // start held high: frames run back to back through a single IDLE cycle.
        w        = $urandom;
        pad_word = w;
        @(negedge clk);
        start = 1'b1;
        wait_valid(2 * FRAME_LAT, a1);
        chk("b2b_first_data", 64'(data), 64'(w));
        wait_valid(2 * FRAME_LAT, a2);
        start = 1'b0;
        chk("b2b_gap", 64'(a2 - a1), 64'(FRAME_LAT + 1));
        chk("b2b_second_data", 64'(data), 64'(w));
        repeat (3) @(negedge clk);
        chk("b2b_idle_busy", {63'd0, busy}, 64'd0);
        chk("b2b_idle_ps", {63'd0, ps}, 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
